// File: rtl/alu_multicycle.sv
// alu_multicycle: registered EX-stage ALU with start/valid handshake; iterative multu/divu built when ALU_MULDIV_EN is defined
module alu_multicycle #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   data_in_1,
   input  logic [WIDTH-1:0]   data_in_2,
   input  logic [SHAMT_W-1:0] shift,
   output logic [WIDTH-1:0]   result,
   output logic [WIDTH-1:0]   result_hi,
   output logic               zero_port,
   output logic               valid,
   output logic               busy,
   output logic               err
);
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_NOR  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ill;
   logic             md_op;
   logic             md_done;
   logic             md_err;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_hi;
   logic             accept;

   // single-cycle operations evaluated straight from the inputs, so the accept edge captures them
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (op)
         OP_ADD:  alu_res = data_in_1 + data_in_2;
         OP_SUB:  alu_res = data_in_1 - data_in_2;
         OP_AND:  alu_res = data_in_1 & data_in_2;
         OP_NOR:  alu_res = ~(data_in_1 | data_in_2);
         OP_OR:   alu_res = data_in_1 | data_in_2;
         OP_SLL:  alu_res = data_in_2 << shift;
         OP_SLT:  alu_res = WIDTH'($signed(data_in_1) < $signed(data_in_2));
         OP_SRL:  alu_res = data_in_2 >> shift;
         OP_SLTU: alu_res = WIDTH'(data_in_1 < data_in_2);
         OP_XOR:  alu_res = data_in_1 ^ data_in_2;
         default: alu_ill = 1'b1;
      endcase
   end

`ifdef ALU_MULDIV_EN
   localparam logic [3:0] OP_MULTU = 4'd10;
   localparam logic [3:0] OP_DIVU  = 4'd11;
   localparam int         CNT_W    = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_rs;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic             div_zero;

   assign md_op    = (op == OP_MULTU) || (op == OP_DIVU);
   assign div_zero = (op == OP_DIVU) && (data_in_2 == '0);
   assign busy     = (state != IDLE);
   assign md_lo    = lo_q;
   assign md_hi    = hi_q;
   // multiply step: add A into the high half when the current multiplier bit is set
   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
   // restoring divide step: shift next dividend bit into the partial remainder and trial-subtract B
   assign div_rs   = {hi_q, lo_q[WIDTH-1]};
   assign div_ge   = div_rs >= {1'b0, b_q};
   assign div_diff = div_rs[WIDTH-1:0] - b_q;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next state and completion strobe; counter at zero means the engine result is ready
   always_comb begin
      state_nx = state;
      md_done  = 1'b0;
      md_err   = 1'b0;
      case (state)
         IDLE: if (start) state_nx = (op == OP_MULTU) ? MUL : (op == OP_DIVU) ? DIV : IDLE;
         MUL: if (cnt == '0) begin
            md_done  = 1'b1;
            state_nx = IDLE;
         end
         DIV: if (cnt == '0) begin
            md_done  = 1'b1;
            md_err   = (b_q == '0);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // engine registers: operands latched at accept, one bit processed per cycle while counting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q  <= '0;
         b_q  <= '0;
         hi_q <= '0;
         lo_q <= '0;
         cnt  <= '0;
      end else if (state == IDLE) begin
         if (start && md_op) begin
            a_q  <= data_in_1;
            b_q  <= data_in_2;
            cnt  <= div_zero ? '0 : CNT_W'(WIDTH);
            hi_q <= div_zero ? data_in_1 : '0;
            lo_q <= (op == OP_MULTU) ? data_in_2 : div_zero ? '1 : data_in_1;
         end
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
         if (state == MUL) begin
            {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
         end else begin
            hi_q <= div_ge ? div_diff : div_rs[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], div_ge};
         end
      end
   end
`else
   assign md_op   = 1'b0;
   assign md_done = 1'b0;
   assign md_err  = 1'b0;
   assign md_lo   = '0;
   assign md_hi   = '0;
   assign busy    = 1'b0;
`endif

   assign accept = start && !busy;

   // output registers: single-cycle results on accept, engine results on completion; valid is a one-cycle pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result    <= '0;
         result_hi <= '0;
         zero_port <= 1'b0;
         valid     <= 1'b0;
         err       <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (accept && !md_op) begin
            result    <= alu_res;
            result_hi <= '0;
            zero_port <= (alu_res == '0);
            err       <= alu_ill;
            valid     <= 1'b1;
         end else if (md_done) begin
            result    <= md_lo;
            result_hi <= md_hi;
            zero_port <= (md_lo == '0);
            err       <= md_err;
            valid     <= 1'b1;
         end
      end
   end
endmodule
